ram_arbiter: RTL

//   Shares one single-port synchronous 1024x8 RAM (ports dout,din,addr,wr,cs,clk) between NREQ requesters.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 55 +++++
 rtl/ram_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter.
// Contents: default geometry (address/data width, requester count, read
// latency) and the access FSM state type.
package ram_arb_pkg;

    localparam int unsigned DEF_AW     = 10;
    localparam int unsigned DEF_DW     = 8;
    localparam int unsigned DEF_NREQ   = 2;
    localparam int unsigned DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester selection for the RAM arbiter.
// Build option: RAM_ARB_RR_EN defined -> round-robin, search starts at
// last_gnt+1 (mod NREQ); undefined -> fixed priority, lowest index wins
// and last_gnt is ignored.
// Ports:
//   req      in  NREQ  pending requests
//   last_gnt in  IW    index of the previous winner
//   gnt      out NREQ  one-hot winner (all zero when no request)
//   idx      out IW    winner index (0 when no request)
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

`ifdef RAM_ARB_RR_EN
    // Walk from farthest to nearest candidate so the nearest set request wins.
    always_comb begin
        logic [IW-1:0] cand;
        idx  = '0;
        cand = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = IW'((int'(last_gnt) + k) % int'(NREQ));
            if (req[cand]) idx = cand;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt;

    // Highest index first so the lowest set request overwrites last.
    always_comb begin
        logic [IW-1:0] cand;
        idx  = '0;
        cand = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = IW'(k);
            if (req[cand]) idx = cand;
        end
    end
`endif

    // One-hot form of the winner.
    always_comb begin
        gnt = '0;
        if (|req) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between NREQ clients: arbitrates,
// issues one access at a time, acks the winner and returns read data.
// Build option: RAM_ARB_RR_EN selects round-robin arbitration (see rr_arbiter).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req/req_we             per-client request and write flag
//   req_addr/req_wdata     packed per-client address / write data
//   ack                    one-cycle pulse when client's access hits the RAM
//   rvalid/rdata           one-cycle read-return pulse and shared read data
//   busy                   FSM not idle
//   ram_addr/din/wr/cs     RAM control, ram_cs high only in ACCESS
//   ram_dout               RAM read data
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    output logic               ram_wr,
    output logic               ram_cs,
    input  logic [DW-1:0]      ram_dout
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t          state, state_n;
    logic [IW-1:0]   gidx, gidx_n;
    logic [IW-1:0]   last_gnt, last_n;
    logic [CW-1:0]   lat_cnt, lat_n;
    logic [NREQ-1:0] ack_n, rvalid_n;
    logic [DW-1:0]   rdata_n, din_n;
    logic [AW-1:0]   addr_n;
    logic            busy_n, wr_n, cs_n;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    // Unpack per-client address / data lanes.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*AW +: AW];
        assign wdata_arr[i] = req_wdata[i*DW +: DW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt),
        .idx      (arb_idx)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gidx     <= '0;
            last_gnt <= IW'(NREQ - 1);
            lat_cnt  <= '0;
            ack      <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wr   <= 1'b0;
            ram_cs   <= 1'b0;
        end else begin
            state    <= state_n;
            gidx     <= gidx_n;
            last_gnt <= last_n;
            lat_cnt  <= lat_n;
            ack      <= ack_n;
            rvalid   <= rvalid_n;
            rdata    <= rdata_n;
            busy     <= busy_n;
            ram_addr <= addr_n;
            ram_din  <= din_n;
            ram_wr   <= wr_n;
            ram_cs   <= cs_n;
        end
    end

    // Next state and next register values; pulses default low.
    always_comb begin
        state_n  = state;
        gidx_n   = gidx;
        last_n   = last_gnt;
        lat_n    = lat_cnt;
        ack_n    = '0;
        rvalid_n = '0;
        rdata_n  = rdata;
        addr_n   = ram_addr;
        din_n    = ram_din;
        wr_n     = 1'b0;
        cs_n     = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = ACCESS;
                    gidx_n  = arb_idx;
                    last_n  = arb_idx;
                    addr_n  = addr_arr[arb_idx];
                    din_n   = wdata_arr[arb_idx];
                    wr_n    = req_we[arb_idx];
                    cs_n    = 1'b1;
                    ack_n   = arb_gnt;
                end
            end
            ACCESS: begin
                // ram_wr still holds the issued op's direction here.
                if (ram_wr) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                    lat_n   = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_n        = IDLE;
                    rdata_n        = ram_dout;
                    rvalid_n[gidx] = 1'b1;
                end else begin
                    lat_n = lat_cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
